// File: rtl/l2_tlb_requester_sv39x4.sv
// L2 TLB requester for Sv39x4 translation.
// Accepts one L1 TLB miss at a time, looks it up in the L2 TLB, and on an L2
// miss launches a page-table walk whose result is written back into the L2
// TLB before the response is returned. Flushes in flight either restart the
// lookup or turn the eventual response into a retry with no fill.
//
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   miss_valid_i/miss_ready_o/miss_req_i     L1 miss request channel
//   l2_tlb_access_o/l2_tlb_req_o             L2 lookup strobe and tag
//   l2_tlb_hit_i/l2_tlb_resp_i               L2 lookup result (LOOKUP_LAT later)
//   l2_tlb_flushing_i                        L2 TLB busy flushing
//   l2_tlb_update_o                          L2 fill, '0 = no write
//   walk_valid_o/walk_ready_i                walk request handshake
//   walk_done_i/walk_error_i/walk_update_i   walk completion and result
//   flush_i                                  SFENCE/HFENCE (any kind)
//   resp_valid_o/resp_ready_i                response handshake
//   resp_hit_o/resp_error_o/resp_retry_o/resp_o   response payload
//   hit_cnt_o/miss_cnt_o                     saturating statistics counters

package l2_tlb_requester_sv39x4_pkg;
  typedef struct packed {
    logic [28:0] vpn;
    logic [15:0] asid;
    logic [13:0] vmid;
  } l2_tlb_req_t;

  typedef struct packed {
    logic [43:0] ppn;
    logic [1:0]  level;
    logic [7:0]  perm;
  } l2_tlb_resp_t;

  typedef struct packed {
    logic         valid;
    l2_tlb_req_t  tag;
    l2_tlb_resp_t entry;
  } l2_tlb_update_sv39x4_t;
endpackage

module l2_tlb_requester_sv39x4
  import l2_tlb_requester_sv39x4_pkg::*;
#(
  parameter int unsigned LOOKUP_LAT = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  l2_tlb_req_t           miss_req_i,
  output logic                  l2_tlb_access_o,
  output l2_tlb_req_t           l2_tlb_req_o,
  input  logic                  l2_tlb_hit_i,
  input  l2_tlb_resp_t          l2_tlb_resp_i,
  input  logic                  l2_tlb_flushing_i,
  output l2_tlb_update_sv39x4_t l2_tlb_update_o,
  output logic                  walk_valid_o,
  input  logic                  walk_ready_i,
  input  logic                  walk_done_i,
  input  logic                  walk_error_i,
  input  l2_tlb_update_sv39x4_t walk_update_i,
  input  logic                  flush_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic                  resp_hit_o,
  output logic                  resp_error_o,
  output logic                  resp_retry_o,
  output l2_tlb_resp_t          resp_o,
  output logic [CNT_W-1:0]      hit_cnt_o,
  output logic [CNT_W-1:0]      miss_cnt_o
);

  typedef enum logic [2:0] {
    IDLE, WAIT_FLUSH, LOOKUP, CHECK, WALK_REQ, WALK_WAIT, UPDATE, RESP
  } state_e;

  state_e                state_q;
  l2_tlb_req_t           req_q;
  l2_tlb_update_sv39x4_t upd_q;
  l2_tlb_resp_t          resp_q;
  logic                  hit_q, err_q, retry_q, drop_q;
  logic [1:0]            lat_q;
  logic [CNT_W-1:0]      hit_cnt_q, miss_cnt_q;
  logic                  fill_block;

  // A fill is abandoned if a flush is pending from the walk phase or hits
  // the L2 TLB in the very cycle the write would happen.
  assign fill_block = flush_i | l2_tlb_flushing_i | drop_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      req_q      <= '0;
      upd_q      <= '0;
      resp_q     <= '0;
      hit_q      <= 1'b0;
      err_q      <= 1'b0;
      retry_q    <= 1'b0;
      drop_q     <= 1'b0;
      lat_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (miss_valid_i) begin
            req_q   <= miss_req_i;
            state_q <= l2_tlb_flushing_i ? WAIT_FLUSH : LOOKUP;
          end
        end
        WAIT_FLUSH: begin
          if (!l2_tlb_flushing_i) state_q <= LOOKUP;
        end
        LOOKUP: begin
          if (l2_tlb_flushing_i) begin
            state_q <= WAIT_FLUSH;
          end else begin
            lat_q   <= 2'(LOOKUP_LAT - 1);
            state_q <= CHECK;
          end
        end
        CHECK: begin
          // Lookup result is sampled when lat_q reaches zero, i.e. exactly
          // LOOKUP_LAT cycles after the access strobe.
          if (flush_i || l2_tlb_flushing_i) begin
            state_q <= WAIT_FLUSH;
          end else if (lat_q != 2'd0) begin
            lat_q <= lat_q - 2'd1;
          end else if (l2_tlb_hit_i) begin
            resp_q  <= l2_tlb_resp_i;
            hit_q   <= 1'b1;
            state_q <= RESP;
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
          end else begin
            state_q <= WALK_REQ;
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
          end
        end
        WALK_REQ: begin
          if (flush_i) drop_q <= 1'b1;
          if (walk_ready_i) state_q <= WALK_WAIT;
        end
        WALK_WAIT: begin
          if (flush_i) drop_q <= 1'b1;
          if (walk_done_i) begin
            state_q <= RESP;
            if (drop_q || flush_i) begin
              retry_q <= 1'b1;
            end else if (walk_error_i) begin
              err_q <= 1'b1;
            end else begin
              upd_q   <= walk_update_i;
              state_q <= UPDATE;
            end
          end
        end
        UPDATE: begin
          if (fill_block) retry_q <= 1'b1;
          state_q <= RESP;
        end
        RESP: begin
          if (resp_ready_i) begin
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
            retry_q <= 1'b0;
            drop_q  <= 1'b0;
            resp_q  <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miss_ready_o    = (state_q == IDLE);
  assign l2_tlb_access_o = (state_q == LOOKUP);
  assign l2_tlb_req_o    = (state_q == IDLE) ? '0 : req_q;
  assign walk_valid_o    = (state_q == WALK_REQ);
  assign l2_tlb_update_o = (state_q == UPDATE && !fill_block) ? upd_q : '0;
  assign resp_valid_o    = (state_q == RESP);
  assign resp_hit_o      = hit_q;
  assign resp_error_o    = err_q;
  assign resp_retry_o    = retry_q;
  assign resp_o          = resp_q;
  assign hit_cnt_o       = hit_cnt_q;
  assign miss_cnt_o      = miss_cnt_q;

endmodule

// File: doc/l2_tlb_requester_sv39x4.md
L2_TLB_REQUESTER_SV39X4 -- requirements
Module: l2_tlb_requester_sv39x4

Interface
REQ-001 SHALL have parameter LOOKUP_LAT, default 1, range 1..3: cycles from l2_tlb_access_o to valid l2_tlb_hit_i/l2_tlb_resp_i.
REQ-002 SHALL have parameter CNT_W, default 16: width of the statistics counters.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk_i  in  1  clock (rising edge); rst_i  in  1  reset.
REQ-004 miss_valid_i  in  1  L1 miss request valid; miss_ready_o  out  1  request accepted; miss_req_i  in  l2_tlb_req_t  lookup tag (vpn/asid/vmid).
REQ-005 l2_tlb_access_o  out  1  lookup strobe; l2_tlb_req_o  out  l2_tlb_req_t  lookup tag; l2_tlb_hit_i  in  1; l2_tlb_resp_i  in  l2_tlb_resp_t; l2_tlb_flushing_i  in  1; l2_tlb_update_o  out  l2_tlb_update_sv39x4_t  fill, '0 = no write.
REQ-006 walk_valid_o  out  1; walk_ready_i  in  1; walk_done_i  in  1; walk_error_i  in  1; walk_update_i  in  l2_tlb_update_sv39x4_t  walk result.
REQ-007 flush_i  in  1  SFENCE/HFENCE flush (any of normal/vvma/gvma).
REQ-008 resp_valid_o  out  1; resp_ready_i  in  1; resp_hit_o  out  1  1 = L2 TLB hit; resp_error_o  out  1  walk fault; resp_retry_o  out  1  dropped by flush; resp_o  out  l2_tlb_resp_t  L2 entry on hit, else '0.
REQ-009 hit_cnt_o  out  CNT_W  L2 hits; miss_cnt_o  out  CNT_W  L2 misses.

Function
REQ-010 SHALL implement FSM states IDLE, WAIT_FLUSH, LOOKUP, CHECK, WALK_REQ, WALK_WAIT, UPDATE, RESP; one request in flight.
REQ-011 IDLE: miss_ready_o=1 (only in IDLE); on miss_valid_i capture miss_req_i into req_q; next WAIT_FLUSH if l2_tlb_flushing_i else LOOKUP.
REQ-012 WAIT_FLUSH: stay while l2_tlb_flushing_i=1; then LOOKUP.
REQ-013 LOOKUP: l2_tlb_access_o=1 exactly one cycle, l2_tlb_req_o=req_q; flushing_i=1 in that cycle -> WAIT_FLUSH (lookup discarded), else CHECK with latency counter loaded.
REQ-014 l2_tlb_req_o SHALL hold req_q in every non-IDLE state; l2_tlb_access_o=0 outside LOOKUP.
REQ-015 CHECK: sample hit/resp exactly LOOKUP_LAT cycles after the access cycle; hit -> capture l2_tlb_resp_i, RESP with resp_hit_o=1, hit_cnt +1; miss -> WALK_REQ, miss_cnt +1.
REQ-016 flush_i or flushing_i during CHECK SHALL discard the lookup, no counter change, -> WAIT_FLUSH.
REQ-017 WALK_REQ: walk_valid_o=1 held until walk_ready_i; then WALK_WAIT.
REQ-018 WALK_WAIT: on walk_done_i: error -> RESP with resp_error_o=1, no fill; else capture walk_update_i into upd_q -> UPDATE.
REQ-019 flush_i in WALK_REQ/WALK_WAIT/UPDATE SHALL set drop_q; walk still awaited; on completion no fill, RESP with resp_retry_o=1, resp_error_o=0.
REQ-020 UPDATE: l2_tlb_update_o=upd_q one cycle (suppressed to '0 if flushing_i or flush_i that cycle, then resp_retry_o=1); '0 in all other states; -> RESP, resp_hit_o=0.
REQ-021 RESP: resp_valid_o and flags held stable until resp_ready_i; then IDLE, flags/drop_q cleared; earliest next accept is the following cycle.
REQ-022 Counters SHALL saturate at 2^CNT_W-1; cleared only by reset.
REQ-023 walk_done_i outside WALK_WAIT and l2_tlb_hit_i outside CHECK sample SHALL be ignored.

Reset
REQ-024 rst_i=1 SHALL asynchronously force IDLE, req_q/upd_q/resp/drop_q='0, counters=0.
REQ-025 During/after reset all outputs 0/'0 except miss_ready_o=1; a request in flight at reset is lost with no response or fill.

Verification
REQ-026 LOOKUP_LAT=1, miss vpn=0x12345, hit=1 in cycle after access -> resp_valid_o with resp_hit_o=1, resp_o=driven entry, hit_cnt_o=1, no walk_valid_o.
REQ-027 Miss, walk_ready_i after 2 cycles, walk_done_i clean -> exactly one cycle l2_tlb_update_o=walk_update_i, then resp_hit_o=0, miss_cnt_o=1.
REQ-028 flushing_i=1 when miss arrives for 5 cycles -> no access until flushing_i low, then single access.
REQ-029 flush_i during WALK_WAIT, then walk_done_i -> l2_tlb_update_o stays '0, resp_retry_o=1.
REQ-030 walk_error_i with walk_done_i -> resp_error_o=1, no fill; resp_ready_i low 4 cycles -> response held, miss_ready_o=0.
REQ-031 CNT_W=2, 5 hits -> hit_cnt_o=3; rst_i pulse mid-walk -> IDLE, all counters 0, no response.
